// File: rtl/stripe_ctrl.sv
// Lane striping sequencer: routes accepted upstream words round-robin onto two
// lanes (or lane 0 only) and inserts a SKP word on every active lane periodically.
module stripe_ctrl #(
    parameter int                 DATA_W       = 32,
    parameter int                 SKP_INTERVAL = 8,
    parameter logic [DATA_W-1:0]  SKP_WORD     = 32'hBC1C1C1C
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_input,
    input  logic              two_lanes,
    output logic              ready,
    output logic [DATA_W-1:0] lane_0,
    output logic [DATA_W-1:0] lane_1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              lane_sel,
    output logic              skp_active
);

    localparam int                CNT_W   = $clog2(SKP_INTERVAL + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SKP_INTERVAL);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STRIPE = 2'd1,
        SKIP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_q, sel_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] lane0_q, lane0_d;
    logic [DATA_W-1:0] lane1_q, lane1_d;
    logic              v0_q, v0_d;
    logic              v1_q, v1_d;
    logic              skp_q, skp_d;

    // Handshake: a word transfers on a rising edge where valid_in and ready are
    // both 1; upstream must hold data_input stable while ready is 0.
    logic accept;
    logic mode_eff;

    assign accept   = valid_in & ready_q;
    // The word accepted on the IDLE edge already uses the freshly sampled mode.
    assign mode_eff = (state_q == IDLE) ? two_lanes : mode_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ready_d = ready_q;
        lane0_d = lane0_q;
        lane1_d = lane1_q;
        v0_d    = 1'b0;
        v1_d    = 1'b0;
        skp_d   = 1'b0;

        case (state_q)
            IDLE, STRIPE: begin
                if (state_q == IDLE) begin
                    mode_d = two_lanes;
                end
                ready_d = 1'b1;
                if (accept) begin
                    if (sel_q) begin
                        lane1_d = data_input;
                        v1_d    = 1'b1;
                    end else begin
                        lane0_d = data_input;
                        v0_d    = 1'b1;
                    end
                    sel_d = mode_eff ? ~sel_q : 1'b0;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_MAX) begin
                        state_d = SKIP;
                        ready_d = 1'b0;
                    end else begin
                        state_d = STRIPE;
                    end
                end else if (!sel_q) begin
                    // Lane 1 still owed a word keeps us in STRIPE.
                    state_d = IDLE;
                end
            end
            SKIP: begin
                lane0_d = SKP_WORD;
                v0_d    = 1'b1;
                if (mode_q) begin
                    lane1_d = SKP_WORD;
                    v1_d    = 1'b1;
                end
                skp_d   = 1'b1;
                cnt_d   = '0;
                sel_d   = 1'b0;
                ready_d = 1'b1;
                state_d = STRIPE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            ready_q <= 1'b0;
            lane0_q <= '0;
            lane1_q <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            skp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            skp_q   <= skp_d;
        end
    end

    assign ready      = ready_q;
    assign lane_0     = lane0_q;
    assign lane_1     = lane1_q;
    assign valid_out0 = v0_q;
    assign valid_out1 = v1_q;
    assign lane_sel   = sel_q;
    assign skp_active = skp_q;

endmodule
